// File: rtl/q_window_avg_pkg.sv
// Shared constants and single-precision arithmetic helpers for the Q window averager
// and the arithmetic pipelines it time-multiplexes.
package q_window_avg_pkg;

    localparam int unsigned SINGLE   = 32;
    localparam logic        ENA_MATH = 1'b1;
    localparam logic        ADD_OP   = 1'b1;
    localparam logic        SUB_OP   = 1'b0;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StAdd  = 3'd1;
    localparam logic [2:0] StSub  = 3'd2;
    localparam logic [2:0] StMul  = 3'd3;
    localparam logic [2:0] StOut  = 3'd4;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Round-to-nearest-even add; negate_b turns it into a - b. Exact x - x gives +0.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic negate_b);
        logic [31:0] bb, big, sml;
        logic [27:0] mb, ms, mask;
        logic [24:0] rm;
        logic        rnd;
        int          eb, es, er, d;
        bb = {b[31] ^ negate_b, b[30:0]};
        if (is_nan(a)) return a;
        if (is_nan(b)) return b;
        if (a[30:23] == 8'hFF) return (bb[30:23] == 8'hFF && bb[31] != a[31]) ? QNAN : a;
        if (bb[30:23] == 8'hFF) return bb;
        if (a[30:0] >= bb[30:0]) begin
            big = a;
            sml = bb;
        end else begin
            big = bb;
            sml = a;
        end
        eb = (big[30:23] == 8'd0) ? 1 : {24'd0, big[30:23]};
        es = (sml[30:23] == 8'd0) ? 1 : {24'd0, sml[30:23]};
        mb = {1'b0, big[30:23] != 8'd0, big[22:0], 3'b000};
        ms = {1'b0, sml[30:23] != 8'd0, sml[22:0], 3'b000};
        d  = eb - es;
        if (d > 26) begin
            ms = {27'd0, |ms};
        end else begin
            mask = (28'd1 << d) - 28'd1;
            ms   = (ms >> d) | {27'd0, |(ms & mask)};
        end
        er = eb;
        if (big[31] == sml[31]) begin
            mb = mb + ms;
            if (mb[27]) begin
                mb = {1'b0, mb[27:2], mb[1] | mb[0]};
                er = er + 1;
            end
        end else begin
            mb = mb - ms;
            if (mb == 28'd0) return 32'h0;
            for (int i = 0; i < 26; i++) begin
                if (!mb[26] && er > 1) begin
                    mb = mb << 1;
                    er = er - 1;
                end
            end
        end
        rnd = mb[2] & (mb[1] | mb[0] | mb[3]);
        rm  = {1'b0, mb[26:3]} + {24'd0, rnd};
        if (rm[24]) begin
            rm = rm >> 1;
            er = er + 1;
        end
        if (er >= 255) return {big[31], 8'hFF, 23'd0};
        if (!rm[23]) er = 0;
        return {big[31], er[7:0], rm[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, rnd, sticky;
        logic [47:0] p, mask;
        logic [24:0] rm;
        int          ea, eb, e, sh;
        s = a[31] ^ b[31];
        if (is_nan(a)) return a;
        if (is_nan(b)) return b;
        if (a[30:23] == 8'hFF) return (b[30:0] == 31'd0) ? QNAN : {s, 8'hFF, 23'd0};
        if (b[30:23] == 8'hFF) return (a[30:0] == 31'd0) ? QNAN : {s, 8'hFF, 23'd0};
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        ea = (a[30:23] == 8'd0) ? 1 : {24'd0, a[30:23]};
        eb = (b[30:23] == 8'd0) ? 1 : {24'd0, b[30:23]};
        p  = {24'd0, a[30:23] != 8'd0, a[22:0]} * {24'd0, b[30:23] != 8'd0, b[22:0]};
        e  = ea + eb - 127;
        if (p[47]) e = e + 1;
        else p = p << 1;
        for (int i = 0; i < 47; i++) begin
            if (!p[47] && e > 1) begin
                p = p << 1;
                e = e - 1;
            end
        end
        if (e < 1) begin
            sh = 1 - e;
            if (sh > 47) begin
                p = {47'd0, |p};
            end else begin
                mask   = (48'd1 << sh) - 48'd1;
                sticky = |(p & mask);
                p      = (p >> sh) | {47'd0, sticky};
            end
            e = 1;
        end
        rnd = p[23] & ((|p[22:0]) | p[24]);
        rm  = {1'b0, p[47:24]} + {24'd0, rnd};
        if (rm[24]) begin
            rm = rm >> 1;
            e  = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (!rm[23]) e = 0;
        return {s, e[7:0], rm[22:0]};
    endfunction

endpackage

// File: rtl/Adder_nodsp.sv
// Pipelined single-precision adder/subtractor: result appears LAT enabled clocks after
// its operands. add_sub high selects addition.
module Adder_nodsp
    import q_window_avg_pkg::*;
#(
    parameter int unsigned LAT = 7
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        add_sub,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    logic [31:0] pipe_q [LAT];

    always_ff @(posedge clk) begin
        if (aclr) begin
            for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
        end else if (clk_en) begin
            pipe_q[0] <= fp_add(dataa, datab, add_sub == SUB_OP);
            for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign result = pipe_q[LAT-1];

endmodule

// File: rtl/Multiplier_nodsp_dsp.sv
// Pipelined single-precision multiplier: result appears LAT enabled clocks after its
// operands.
module Multiplier_nodsp_dsp
    import q_window_avg_pkg::*;
#(
    parameter int unsigned LAT = 5
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    logic [31:0] pipe_q [LAT];

    always_ff @(posedge clk) begin
        if (aclr) begin
            for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
        end else if (clk_en) begin
            pipe_q[0] <= fp_mul(dataa, datab);
            for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign result = pipe_q[LAT-1];

endmodule

// File: rtl/q_ring_buf.sv
// Sample history ring: synchronous write at wr_ptr, combinational read of the entry
// about to be overwritten.
module q_ring_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW-1:0]    wr_ptr
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            ptr_q <= '0;
        end else if (we) begin
            mem_q[ptr_q] <= wdata;
            ptr_q        <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    assign rdata  = mem_q[ptr_q];
    assign wr_ptr = ptr_q;

endmodule

// File: rtl/q_window_avg.sv
// Sliding-window mean of the Q stream using one shared adder and one multiplier,
// sequenced by a small FSM: sum += new, sum -= oldest, avg = sum * 1/DEPTH.
module q_window_avg
    import q_window_avg_pkg::*;
#(
    parameter int unsigned       WIDTH     = SINGLE,
    parameter int unsigned       DEPTH     = 8,
    parameter int unsigned       AW        = $clog2(DEPTH),
    parameter int unsigned       ADD_LAT   = 7,
    parameter int unsigned       MUL_LAT   = 5,
    parameter logic [WIDTH-1:0]  INV_DEPTH = 32'h3E000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sta,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_avg,
    output logic             done_sig,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned MaxLat = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             phase_end, overrun_q;
    logic [WIDTH-1:0] q_new_q, q_old_q, sum_q, sum_tmp_q, q_avg_q;
    logic [WIDTH-1:0] add_a, add_b, add_res, mul_res, ring_rd;
    logic             add_op;
    logic [AW-1:0]    wr_ptr;

    // Each phase holds its operands for LAT+1 cycles and takes the result on the last one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        phase_end = 1'b0;
        case (state_q)
            StIdle: if (sta) state_d = StAdd;
            StAdd, StSub: begin
                phase_end = (cnt_q == CntW'(ADD_LAT));
                cnt_d     = cnt_q + 1'b1;
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = (state_q == StAdd) ? StSub : StMul;
                end
            end
            StMul: begin
                phase_end = (cnt_q == CntW'(MUL_LAT));
                cnt_d     = cnt_q + 1'b1;
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = StOut;
                end
            end
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign add_a  = (state_q == StSub) ? sum_tmp_q : sum_q;
    assign add_b  = (state_q == StSub) ? q_old_q : q_new_q;
    assign add_op = (state_q == StSub) ? SUB_OP : ADD_OP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            q_new_q   <= '0;
            q_old_q   <= '0;
            sum_q     <= '0;
            sum_tmp_q <= '0;
            q_avg_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && sta) begin
                q_new_q <= Q;
                q_old_q <= ring_rd;
            end
            if (phase_end) begin
                case (state_q)
                    StAdd:   sum_tmp_q <= add_res;
                    StSub:   sum_q     <= add_res;
                    StMul:   q_avg_q   <= mul_res;
                    default: ;
                endcase
            end
            if (sta && state_q != StIdle) overrun_q <= 1'b1;
        end
    end

    q_ring_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .we     (state_q == StSub && phase_end),
        .wdata  (q_new_q),
        .rdata  (ring_rd),
        .wr_ptr (wr_ptr)
    );

    Adder_nodsp #(
        .LAT (ADD_LAT)
    ) u_add (
        .clk     (clk),
        .aclr    (1'b0),
        .clk_en  (ENA_MATH),
        .add_sub (add_op),
        .dataa   (add_a),
        .datab   (add_b),
        .result  (add_res)
    );

    Multiplier_nodsp_dsp #(
        .LAT (MUL_LAT)
    ) u_mul (
        .clk    (clk),
        .aclr   (1'b0),
        .clk_en (ENA_MATH),
        .dataa  (sum_q),
        .datab  (INV_DEPTH),
        .result (mul_res)
    );

    assign Q_avg    = q_avg_q;
    assign done_sig = (state_q == StOut);
    assign busy     = (state_q != StIdle);
    assign overrun  = overrun_q;

endmodule
